// File: rtl/aes_job_arbiter_pkg.sv
// Shared AES front-end types: core mode encoding, arbiter state, captured job.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package aes_job_arbiter_pkg;

    // Widest requester id the arbiter supports (NUM_REQ up to 8).
    localparam int ID_W = 3;

    typedef enum logic [1:0] {
        AES_128     = 2'b00,
        AES_192     = 2'b01,
        AES_256     = 2'b10,
        AES_INVALID = 2'b11
    } aes_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    typedef struct packed {
        aes_mode_e       mode;
        logic [127:0]    plain;
        logic [255:0]    key;
        logic [ID_W-1:0] id;
    } job_t;

    function automatic logic is_valid_mode(input aes_mode_e m);
        return m != AES_INVALID;
    endfunction

endpackage

// File: rtl/aes_job_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; en low forces an all-zero grant.
module aes_job_arbiter_rr_arbiter #(
    parameter int  N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester to ptr wins.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        cand = '0;
        if (en) begin
            for (int off = N - 1; off >= 0; off--) begin
                cand = IW'((int'(ptr) + off) % N);
                if (req[cand]) begin
                    gnt       = '0;
                    gnt[cand] = 1'b1;
                    idx       = cand;
                end
            end
        end
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one AES core among NUM_REQ requesters; resets the core between jobs. Optional macro AES_ARB_TIMEOUT_EN adds a RUN timeout.
// Latency: accept at T -> RUN at T+1; done seen at D -> response at D+1; invalid mode -> response at T+1.
// Backpressure: response held stable until rsp_ready_i; no new grant until the cycle after the handshake.
module aes_job_arbiter
    import aes_job_arbiter_pkg::*;
#(
    parameter int  NUM_REQ        = 4,
    parameter int  TIMEOUT_CYCLES = 1023,
    localparam int IW             = $clog2(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ-1:0][1:0]   req_type_i,
    input  logic [NUM_REQ-1:0][127:0] req_plain_i,
    input  logic [NUM_REQ-1:0][255:0] req_key_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [IW-1:0]             rsp_id_o,
    output logic [127:0]              rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      core_rst_no,
    output logic                      core_ready_o,
    output logic [1:0]                core_type_o,
    output logic [127:0]              core_plain_o,
    output logic [255:0]              core_key_o,
    input  logic                      core_done_i,
    input  logic [127:0]              core_text_i
);

    arb_state_e          state_q, state_d;
    job_t                job_q, job_d;
    logic                job_load;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [127:0]        rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;
    logic                core_rst_q, core_rst_d;
    logic [NUM_REQ-1:0]  gnt;
    logic [IW-1:0]       gnt_idx;
    logic                unused_bits;

    // Grants only in IDLE; gating with rst_ni keeps req_ready_o low while held in reset.
    aes_job_arbiter_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req (req_valid_i),
        .ptr (ptr_q),
        .en  ((state_q == ST_IDLE) && rst_ni),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign job_d = '{mode:  aes_mode_e'(req_type_i[gnt_idx]),
                     plain: req_plain_i[gnt_idx],
                     key:   req_key_i[gnt_idx],
                     id:    ID_W'(gnt_idx)};

`ifdef AES_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] run_cnt_q;
    logic [CW-1:0] run_cnt_nxt;
    logic          to_hit;

    // Counter holds the number of RUN cycles completed; timeout fires on the cycle it would reach the limit.
    assign run_cnt_nxt = run_cnt_q + 1'b1;
    assign to_hit      = (run_cnt_nxt == CW'(TIMEOUT_CYCLES));

    // RUN cycle counter, cleared on every accept into RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt_q <= '0;
        end else if (state_q == ST_IDLE && state_d == ST_RUN) begin
            run_cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            run_cnt_q <= run_cnt_nxt;
        end
    end
`endif

    // Next-state and per-state outputs; response fields only change on entry to RESP.
    always_comb begin
        state_d      = state_q;
        job_load     = 1'b0;
        ptr_d        = ptr_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        core_rst_d   = core_rst_q;
        req_ready_o  = '0;
        rsp_valid_o  = 1'b0;
        core_ready_o = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                req_ready_o = gnt;
                if (|gnt) begin
                    job_load = 1'b1;
                    ptr_d    = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    if (!is_valid_mode(job_d.mode)) begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                        rsp_err_d  = 1'b1;
                    end else begin
                        state_d    = ST_RUN;
                        core_rst_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                core_ready_o = 1'b1;
                if (core_done_i) begin
                    state_d    = ST_RESP;
                    rsp_data_d = core_text_i;
                    rsp_err_d  = 1'b0;
                    core_rst_d = 1'b0;
                end
`ifdef AES_ARB_TIMEOUT_EN
                else if (to_hit) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    core_rst_d = 1'b0;
                end
`endif
            end
            ST_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                core_rst_d = 1'b0;
            end
        endcase
    end

    // State, job, pointer and response registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            job_q      <= '0;
            ptr_q      <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            core_rst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            core_rst_q <= core_rst_d;
            if (job_load) begin
                job_q <= job_d;
            end
        end
    end

    // Core inputs come straight from the job registers so they stay fixed for the whole job.
    assign core_rst_no  = core_rst_q;
    assign core_type_o  = job_q.mode;
    assign core_plain_o = job_q.plain;
    assign core_key_o   = job_q.key;
    assign rsp_id_o     = job_q.id[IW-1:0];
    assign rsp_data_o   = rsp_data_q;
    assign rsp_err_o    = rsp_err_q;

    // Id bits above IW and the timeout limit in the default build have no other reader.
    assign unused_bits = ^{job_q.id, TIMEOUT_CYCLES};

endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Round-robin front end that shares one AES encryption core between NUM_REQ requesters. It captures a job (mode, plaintext, key), releases the core from reset, and starts it. It then waits for the core's done flag, returns the ciphertext tagged with the requester id, and parks the core in reset between jobs. The core latches done permanently, so a per-job core reset is mandatory.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters (2..8)
- TIMEOUT_CYCLES, 1023: maximum cycles in RUN before a job is aborted (timeout build only)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i  in  NUM_REQ  per-requester job valid
- req_ready_o  out  NUM_REQ  one-hot accept pulse
- req_type_i  in  NUM_REQ x 2  mode: 00 AES-128, 01 AES-192, 10 AES-256, 11 invalid
- req_plain_i  in  NUM_REQ x 128  plaintext
- req_key_i  in  NUM_REQ x 256  key, left-justified (a 128-bit key sits in [255:128])
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accept
- rsp_id_o  out  clog2(NUM_REQ)  requester index of the response
- rsp_data_o  out  128  ciphertext (0 on error)
- rsp_err_o  out  1  invalid type or timeout
- core_rst_no  out  1  registered active-low reset to the core
- core_ready_o  out  1  start to the core
- core_type_o  out  2  mode to the core
- core_plain_o  out  128  plaintext to the core
- core_key_o  out  256  key to the core
- core_done_i  in  1  core done (sticky until core reset)
- core_text_i  in  128  core ciphertext

## Operation
- FSM states are IDLE, RUN and RESP. Reset state is IDLE.
- IDLE:
  - Round-robin pick among the asserted req_valid_i, starting at ptr.
  - req_ready_o[g] is asserted combinationally in the same cycle, for 1 cycle.
  - That cycle registers type, plain, key and id into the job registers, and sets ptr to g+1 (mod NUM_REQ).
  - Type 11 goes to RESP with err=1 and data=0. The core is never started.
  - Any other type goes to RUN. core_rst_no is set to 1 at the same edge.
- RUN:
  - core_ready_o = 1. core_type/plain/key_o are driven from the job registers and held stable through the whole job, because the core uses the mode combinationally every cycle.
  - On core_done_i = 1: capture core_text_i into the response register, go to RESP, and clear core_rst_no to 0 at the same edge.
- RESP:
  - rsp_valid_o = 1. id, data and err are stable until rsp_valid_o && rsp_ready_i; that handshake returns to IDLE.
  - No grant is made while in RESP. req_ready_o is all-zero outside IDLE.
- core_rst_no is 0 in IDLE and RESP and 1 only in RUN, so the core always starts from its INIT state.
- Reset mid-operation: all outputs go to reset values asynchronously, the in-flight job is dropped with no response, and ptr returns to 0.
- A requester deasserting valid before it is granted is legal; its job is never taken.

## Timing
- Output reset values: req_ready_o=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_err_o=0, core_rst_no=0, core_ready_o=0, core_type_o=0, core_plain_o=0, core_key_o=0.
- Accept at cycle T means RUN from T+1. The core executes INIT at T+1 and samples start at the edge ending T+2.
- core_done_i seen high at cycle D gives rsp_valid_o at D+1.
- Arbiter overhead per job: 2 cycles plus the response stall.
- Invalid type accepted at T gives rsp_valid_o at T+1.
- Back-to-back: the earliest next accept is the cycle after the response handshake.

## Configuration
- AES_ARB_TIMEOUT_EN, defined:
  - A cycle counter of clog2(TIMEOUT_CYCLES+1) bits clears on entry to RUN and increments each RUN cycle.
  - When it reaches TIMEOUT_CYCLES with core_done_i still low, go to RESP with err=1 and data=0, and reset the core.
  - Done and timeout in the same cycle: done wins.
- AES_ARB_TIMEOUT_EN, undefined: no counter exists, and RUN waits on core_done_i indefinitely.

## Structure
- Shared AES package:
  - mode typedef: AES_128=2'b00, AES_192=2'b01, AES_256=2'b10, AES_INVALID=2'b11
  - arbiter state enum
  - job struct {type, plain, key, id}
- Sub-module rr_arbiter (parameter N): inputs req vector, ptr and enable; outputs one-hot grant and index. Purely combinational, reusable.

## Test plan
- AES-128 vector via requester 0:
  - stimulus: key 000102030405060708090a0b0c0d0e0f (left-justified), plain 00112233445566778899aabbccddeeff
  - response: rsp_data_o = 69c4e0d86a7b0430d8cdb78070b4c55a, id 0, err 0
- AES-256 vector via requester 3:
  - stimulus: key 00..1f, same plaintext
  - response: 8ea2b7ca516745bfeafc49904b496089, id 3
- Round robin: requesters 0 and 2 are continuously valid, so the grant order is 0, 2, 0, 2. No grant occurs while rsp_valid_o=1.
- Invalid type 11 from requester 1: rsp at T+1 with err=1 and data=0. core_rst_no never rises.
- Backpressure:
  - stimulus: rsp_ready_i held low for 10 cycles
  - response: id, data and err stable, core_rst_no=0, req_ready_o=0
- With AES_ARB_TIMEOUT_EN and a stub core that never asserts done, TIMEOUT_CYCLES=20: err response after 20 RUN cycles.
- rst_ni pulsed low mid-RUN: all outputs are zero immediately and no response occurs. A fresh job afterwards completes correctly.
